// File: rtl/dm_sized.sv
// Data memory for the MIPS MEM stage: sized stores with lane merge, signed/unsigned loads,
// registered one-cycle ack, sequential clear on reset. Define DM_TRACE_EN to print store traces.
module dm_sized #(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        misalign
);
  // Handshake: a request is taken on any rising edge where req=1 and ready=1 (and rst=0);
  // ack pulses for exactly one cycle on the following cycle, with rdata/misalign valid then.
  typedef enum logic {CLEAR, IDLE} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   cnt, cnt_nxt;
  logic [31:0]     mem [DEPTH];

  logic [AW-1:0]   idx;
  logic [31:0]     cur, merged, ld_val;
  logic            bad, accept, st_wen, wen;
  logic [AW-1:0]   widx;
  logic [31:0]     wval;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;

  assign ready  = (state == IDLE);
  assign idx    = addr[AW+1:2];
  assign cur    = mem[idx];
  assign accept = req && ready && !rst;
  assign bad    = (size == 2'b11) ||
                  (size == 2'b01 && addr[0]) ||
                  (size == 2'b10 && addr[1:0] != 2'b00);
  assign st_wen = accept && we && !bad;
  assign wen    = !rst && ((state == CLEAR) || st_wen);
  assign widx   = (state == CLEAR) ? cnt : idx;
  assign wval   = (state == CLEAR) ? 32'h0 : merged;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == CLEAR) begin
      cnt_nxt = cnt + AW'(1);
      if (cnt == AW'(DEPTH - 1)) state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    merged = cur;
    case (size)
      2'b00:   merged[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
      2'b01:   merged[{addr[1], 4'b0000} +: 16] = wdata[15:0];
      default: merged = wdata;
    endcase
  end

  assign byte_v = cur[{addr[1:0], 3'b000} +: 8];
  assign half_v = cur[{addr[1], 4'b0000} +: 16];

  always_comb begin
    ld_val = cur;
    case (size)
      2'b00:   ld_val = sign ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
      2'b01:   ld_val = sign ? {{16{half_v[15]}}, half_v} : {16'h0, half_v};
      default: ld_val = cur;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wen) mem[widx] <= wval;
  end

  // rdata holds between acks; stores and faulting accesses report zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack      <= 1'b0;
      misalign <= 1'b0;
      rdata    <= 32'h0;
    end else begin
      ack      <= accept;
      misalign <= accept && bad;
      if (accept) rdata <= (bad || we) ? 32'h0 : ld_val;
    end
  end

`ifdef DM_TRACE_EN
  always_ff @(posedge clk) begin
    if (st_wen) $display("@%08h: *%08h <= %08h", pc, {addr[31:2], 2'b00}, merged);
  end
`else
  logic unused_bits;
  assign unused_bits = ^{pc, addr[31:AW+2]};
`endif
endmodule

// File: tb/tb_dm_sized.sv
// Scoreboard bench for dm_sized (DEPTH=16): directed vectors push expected {misalign, rdata},
// an independent monitor pops on every ack.
module tb_dm_sized;
  logic        clk = 1'b0;
  logic        rst, req, we, sign;
  logic [1:0]  size;
  logic [31:0] addr, wdata, pc;
  logic        ready, ack, misalign;
  logic [31:0] rdata;

  int tests = 0;
  int fails = 0;
  logic [32:0] exp_q[$];

  dm_sized #(.DEPTH(16)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sign(sign),
    .addr(addr), .wdata(wdata), .pc(pc), .ready(ready), .rdata(rdata),
    .ack(ack), .misalign(misalign)
  );

  always #5 clk = ~clk;

  // Monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [32:0] e;
    if (ack) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_ack: got ack with misalign=%0b rdata=%08h, required no ack", misalign, rdata);
      end else begin
        e = exp_q.pop_front();
        if ({misalign, rdata} !== e) begin
          fails++;
          $display("FAIL ack_data: got misalign=%0b rdata=%08h, required misalign=%0b rdata=%08h",
                   misalign, rdata, e[32], e[31:0]);
        end
      end
    end else if (misalign !== 1'b0) begin
      fails++;
      $display("FAIL misalign_no_ack: got misalign=%0b without ack, required 0", misalign);
    end
  end

  task automatic issue(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input logic [31:0] d, input logic exp_mis, input logic [31:0] exp_rd);
    int guard = 0;
    while (ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got ready=%0b, required 1", ready);
    end
    we = w; size = sz; sign = sg; addr = a; wdata = d; pc = 32'h0040_0000 + a; req = 1'b1;
    exp_q.push_back({exp_mis, exp_rd});
    @(negedge clk);
    req = 1'b0;
  endtask

  // Counts negedges with ready low from the current (first post-reset) negedge.
  task automatic count_clear(input string name, input int required, input bit poke);
    int n = 0;
    while (ready !== 1'b1 && n < 100) begin
      if (poke && n == 3) begin
        we = 1'b1; size = 2'b10; addr = 32'h0; wdata = 32'hDEAD_BEEF; req = 1'b1;
      end else begin
        req = 1'b0;
      end
      n++;
      @(negedge clk);
    end
    req = 1'b0;
    tests++;
    if (n != required) begin
      fails++;
      $display("FAIL %s: got %0d busy cycles, required %0d", name, n, required);
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; req = 1'b0; we = 1'b0; size = 2'b10; sign = 1'b0;
    addr = 32'h0; wdata = 32'h0; pc = 32'h0;

    do_reset(2);
    tests++;
    if (ready !== 1'b0 || ack !== 1'b0 || rdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_state: got ready=%0b ack=%0b rdata=%08h, required 0 0 00000000", ready, ack, rdata);
    end
    count_clear("clear_len", 16, 1'b1);
    issue(1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 1'b0, 32'h0000_0000);

    // Word store/load, then byte and half merge.
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678, 1'b0, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         1'b0, 32'h1234_5678);
    issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AB, 1'b0, 32'h0);
    issue(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_BEEF, 1'b0, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         1'b0, 32'hBEEF_AB78);

    // Load extension.
    issue(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1'b0, 32'hFFFF_FFAB);
    issue(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1'b0, 32'h0000_00AB);
    issue(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0, 32'hFFFF_BEEF);
    issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0, 32'h0000_BEEF);
    issue(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 1'b0, 32'h0000_0078);

    // Misalignment and illegal size.
    issue(1'b1, 2'b10, 1'b0, 32'h12, 32'hFFFF_FFFF, 1'b1, 32'h0);
    issue(1'b1, 2'b01, 1'b0, 32'h11, 32'hFFFF_FFFF, 1'b1, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         1'b0, 32'hBEEF_AB78);
    issue(1'b0, 2'b11, 1'b1, 32'h10, 32'h0,         1'b1, 32'h0);
    issue(1'b0, 2'b01, 1'b1, 32'h13, 32'h0,         1'b1, 32'h0);

    // Address wrap: 0x40 aliases word 0 with DEPTH=16.
    issue(1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFE_F00D, 1'b0, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h00, 32'h0,         1'b0, 32'hCAFE_F00D);
    issue(1'b1, 2'b10, 1'b0, 32'h3C, 32'h0BAD_0BAD, 1'b0, 32'h0);
    repeat (2) @(negedge clk);

    // Reset in the middle of a clear must restart the count.
    do_reset(1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    count_clear("clear_restart", 16, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h3C, 32'h0, 1'b0, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 1'b0, 32'h0);
    repeat (3) @(negedge clk);

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL missing_acks: got %0d outstanding expectations, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
